// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction queue between ifetch and decode. Stores up to DEPTH fetched
//   instructions (instruction, address, next address, fault flag) in a
//   circular buffer. Both sides use the stall handshake. A flush empties the
//   queue. After a faulting fetch is accepted, no further input is taken until
//   the next flush.
//
// Ports
//   clk, rst                 core clock, asynchronous active-low reset
//   flush                    synchronous pipeline flush (priority over push/pop)
//   in_instruction/addr/next_addr/exception   fetched entry
//   prev_stalled             input not valid
//   stall_prev               queue not ready to accept input
//   out_instruction/addr/next_addr/exception  head entry (don't-care when empty)
//   next_stalled             decode not ready
//   stall_next               output not valid (registered state only)
//   level                    number of occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter  int ILEN  = 32,
  parameter  int ALEN  = 32,
  parameter  int DEPTH = 4,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [ILEN-1:0] in_instruction,
  input  logic [ALEN-1:0] in_addr,
  input  logic [ALEN-1:0] in_next_addr,
  input  logic            in_exception,
  input  logic            prev_stalled,
  output logic            stall_prev,
  output logic [ILEN-1:0] out_instruction,
  output logic [ALEN-1:0] out_addr,
  output logic [ALEN-1:0] out_next_addr,
  output logic            out_exception,
  input  logic            next_stalled,
  output logic            stall_next,
  output logic [LW-1:0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ILEN + 2 * ALEN + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [LW-1:0] count;
  logic          fault_held;
  logic          push;
  logic          pop;

  // Ready depends only on registered state and flush, so a full queue cannot
  // take a push in the same cycle as a pop (no combinational path from decode).
  assign stall_prev = !rst || flush || (count == FULL) || fault_held;
  assign stall_next = (count == '0);

  assign push = !prev_stalled && !stall_prev;
  assign pop  = !stall_next && !next_stalled && !flush;

  assign {out_instruction, out_addr, out_next_addr, out_exception} = mem[rptr];
  assign level = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      fault_held <= 1'b0;
    end else if (flush) begin
      rptr       <= '0;
      wptr       <= '0;
      count      <= '0;
      fault_held <= 1'b0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
        if (in_exception) fault_held <= 1'b1;
      end
      if (pop) rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so out_* read as zero while empty after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wptr] <= {in_instruction, in_addr, in_next_addr, in_exception};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] in_instruction = '0;
  logic [31:0] in_addr = '0;
  logic [31:0] in_next_addr = '0;
  logic        in_exception = 1'b0;
  logic        prev_stalled = 1'b1;
  logic        stall_prev;
  logic [31:0] out_instruction;
  logic [31:0] out_addr;
  logic [31:0] out_next_addr;
  logic        out_exception;
  logic        next_stalled = 1'b1;
  logic        stall_next;
  logic [2:0]  level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] fill_instr [4] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
  logic [31:0] fill_addr  [4] = '{32'h0, 32'h4, 32'h8, 32'hC};

  fetch_queue #(.ILEN(32), .ALEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_instruction(in_instruction), .in_addr(in_addr),
    .in_next_addr(in_next_addr), .in_exception(in_exception),
    .prev_stalled(prev_stalled), .stall_prev(stall_prev),
    .out_instruction(out_instruction), .out_addr(out_addr),
    .out_next_addr(out_next_addr), .out_exception(out_exception),
    .next_stalled(next_stalled), .stall_next(stall_next), .level(level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] a, input logic exc);
    in_addr        = a;
    in_next_addr   = a + 32'd4;
    in_instruction = a ^ 32'hC0DE_0000;
    in_exception   = exc;
    prev_stalled   = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (level !== 3'd0) $display("FAIL reset_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (stall_next !== 1'b1) $display("FAIL reset_stall_next got %b exp 1", stall_next); else n_pass++;
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL reset_stall_prev got %b exp 1", stall_prev); else n_pass++;
    n_checks++; if (out_instruction !== 32'h0) $display("FAIL reset_out_instr got %h exp 0", out_instruction); else n_pass++;
    step();
    rst = 1'b1;
    #1;
    n_checks++; if (stall_prev !== 1'b0) $display("FAIL reset_release_stall_prev got %b exp 0", stall_prev); else n_pass++;
  endtask

  task automatic test_fill_drain();
    next_stalled = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer(fill_addr[i], 1'b0);
      in_instruction = fill_instr[i];
      step();
    end
    n_checks++; if (level !== 3'd4) $display("FAIL fill_level got %0d exp 4", level); else n_pass++;
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL fill_stall_prev got %b exp 1", stall_prev); else n_pass++;
    offer(32'h10, 1'b0);
    step();
    n_checks++; if (level !== 3'd4) $display("FAIL fill_fifth_rejected level got %0d exp 4", level); else n_pass++;
    prev_stalled = 1'b1;
    next_stalled = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (stall_next !== 1'b0) $display("FAIL drain_valid[%0d] stall_next got %b exp 0", i, stall_next); else n_pass++;
      n_checks++; if (out_addr !== fill_addr[i]) $display("FAIL drain_addr[%0d] got %h exp %h", i, out_addr, fill_addr[i]); else n_pass++;
      n_checks++; if (out_instruction !== fill_instr[i]) $display("FAIL drain_instr[%0d] got %h exp %h", i, out_instruction, fill_instr[i]); else n_pass++;
      n_checks++; if (out_next_addr !== fill_addr[i] + 32'd4) $display("FAIL drain_next[%0d] got %h exp %h", i, out_next_addr, fill_addr[i] + 32'd4); else n_pass++;
      step();
    end
    n_checks++; if (level !== 3'd0) $display("FAIL drain_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (stall_next !== 1'b1) $display("FAIL drain_empty got %b exp 1", stall_next); else n_pass++;
  endtask

  task automatic test_streaming();
    next_stalled = 1'b0;
    for (int i = 0; i < 20; i++) begin
      offer(32'h100 + 32'(i) * 32'd4, 1'b0);
      step();
      n_checks++; if (level !== 3'd1) $display("FAIL stream_level[%0d] got %0d exp 1", i, level); else n_pass++;
      n_checks++; if (out_addr !== 32'h100 + 32'(i) * 32'd4) $display("FAIL stream_addr[%0d] got %h exp %h", i, out_addr, 32'h100 + 32'(i) * 32'd4); else n_pass++;
    end
    prev_stalled = 1'b1;
    step();
    n_checks++; if (level !== 3'd0) $display("FAIL stream_tail_level got %0d exp 0", level); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_q[$];
    int pushed = 0;
    int popped = 0;
    int cyc = 0;
    bit do_push, do_pop;
    while (popped < 37 && cyc < 600) begin
      if (pushed < 37 && ($urandom % 3) != 0) offer(32'h1000 + 32'(pushed) * 32'd4, 1'b0);
      else prev_stalled = 1'b1;
      next_stalled = (($urandom % 3) == 0);
      #1;
      n_checks++; if (level !== 3'(exp_q.size())) $display("FAIL wrap_level cyc %0d got %0d exp %0d", cyc, level, exp_q.size()); else n_pass++;
      n_checks++; if (stall_prev !== (exp_q.size() == 4)) $display("FAIL wrap_stall_prev cyc %0d got %b exp %b", cyc, stall_prev, exp_q.size() == 4); else n_pass++;
      do_push = !prev_stalled && exp_q.size() < 4;
      do_pop  = !next_stalled && exp_q.size() > 0;
      if (do_pop) begin
        n_checks++; if (out_addr !== exp_q[0]) $display("FAIL wrap_pop %0d got %h exp %h", popped, out_addr, exp_q[0]); else n_pass++;
        void'(exp_q.pop_front());
        popped++;
      end
      if (do_push) begin
        exp_q.push_back(in_addr);
        pushed++;
      end
      step();
      cyc++;
    end
    n_checks++; if (popped !== 37) $display("FAIL wrap_timeout popped %0d exp 37", popped); else n_pass++;
    prev_stalled = 1'b1;
    next_stalled = 1'b1;
  endtask

  task automatic test_flush();
    next_stalled = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'h200 + 32'(i) * 32'd4, 1'b0);
      step();
    end
    n_checks++; if (level !== 3'd3) $display("FAIL flush_pre_level got %0d exp 3", level); else n_pass++;
    offer(32'h20C, 1'b0);
    next_stalled = 1'b0;
    flush = 1'b1;
    #1;
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL flush_cycle_stall_prev got %b exp 1", stall_prev); else n_pass++;
    step();
    flush = 1'b0;
    prev_stalled = 1'b1;
    #1;
    n_checks++; if (level !== 3'd0) $display("FAIL flush_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (stall_next !== 1'b1) $display("FAIL flush_stall_next got %b exp 1", stall_next); else n_pass++;
    n_checks++; if (stall_prev !== 1'b0) $display("FAIL flush_after_stall_prev got %b exp 0", stall_prev); else n_pass++;
    offer(32'h300, 1'b0);
    step();
    prev_stalled = 1'b1;
    n_checks++; if (out_addr !== 32'h300) $display("FAIL flush_new_head got %h exp 300", out_addr); else n_pass++;
    step();
    n_checks++; if (level !== 3'd0) $display("FAIL flush_new_drain level got %0d exp 0", level); else n_pass++;
  endtask

  task automatic test_fault_hold();
    next_stalled = 1'b1;
    offer(32'h10, 1'b1);
    step();
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL fault_stall_prev got %b exp 1", stall_prev); else n_pass++;
    offer(32'h14, 1'b0);
    step();
    n_checks++; if (level !== 3'd1) $display("FAIL fault_reject level got %0d exp 1", level); else n_pass++;
    next_stalled = 1'b0;
    #1;
    n_checks++; if (out_addr !== 32'h10) $display("FAIL fault_head_addr got %h exp 10", out_addr); else n_pass++;
    n_checks++; if (out_exception !== 1'b1) $display("FAIL fault_head_exc got %b exp 1", out_exception); else n_pass++;
    step();
    step();
    n_checks++; if (level !== 3'd0) $display("FAIL fault_drained level got %0d exp 0", level); else n_pass++;
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL fault_held_stall_prev got %b exp 1", stall_prev); else n_pass++;
    flush = 1'b1;
    step();
    flush = 1'b0;
    #1;
    n_checks++; if (stall_prev !== 1'b0) $display("FAIL fault_cleared_stall_prev got %b exp 0", stall_prev); else n_pass++;
    step();
    prev_stalled = 1'b1;
    n_checks++; if (out_addr !== 32'h14) $display("FAIL fault_retry_addr got %h exp 14", out_addr); else n_pass++;
    n_checks++; if (out_exception !== 1'b0) $display("FAIL fault_retry_exc got %b exp 0", out_exception); else n_pass++;
    step();
    n_checks++; if (level !== 3'd0) $display("FAIL fault_retry_drain level got %0d exp 0", level); else n_pass++;
  endtask

  task automatic test_async_reset();
    next_stalled = 1'b1;
    offer(32'h400, 1'b0);
    step();
    offer(32'h404, 1'b0);
    step();
    n_checks++; if (level !== 3'd2) $display("FAIL areset_pre_level got %0d exp 2", level); else n_pass++;
    offer(32'h408, 1'b0);
    next_stalled = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    n_checks++; if (level !== 3'd0) $display("FAIL areset_level got %0d exp 0", level); else n_pass++;
    n_checks++; if (stall_next !== 1'b1) $display("FAIL areset_stall_next got %b exp 1", stall_next); else n_pass++;
    n_checks++; if (out_instruction !== 32'h0) $display("FAIL areset_out_instr got %h exp 0", out_instruction); else n_pass++;
    n_checks++; if (stall_prev !== 1'b1) $display("FAIL areset_stall_prev got %b exp 1", stall_prev); else n_pass++;
    step();
    n_checks++; if (level !== 3'd0) $display("FAIL areset_held_level got %0d exp 0", level); else n_pass++;
    #2;
    rst = 1'b1;
    offer(32'h500, 1'b0);
    step();
    prev_stalled = 1'b1;
    n_checks++; if (level !== 3'd1) $display("FAIL areset_first_push level got %0d exp 1", level); else n_pass++;
    n_checks++; if (out_addr !== 32'h500) $display("FAIL areset_first_addr got %h exp 500", out_addr); else n_pass++;
    step();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_wrap();
    test_flush();
    test_fault_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction queue inserted between `ifetch` and `decode` in the core pipeline. It decouples fetch latency from decode back-pressure: up to DEPTH fetched instructions are stored, each with its address, next address and fetch-exception flag. Both sides use the core's standard stall handshake. The queue discards its contents on a pipeline flush, and stops accepting input after a faulting fetch until the next flush.

## Interface
Parameters:
- ILEN, 32, instruction width
- ALEN, 32, address width
- DEPTH, 4, number of entries; power of two, >= 2
- LW, $clog2(DEPTH+1), width of `level` (derived, not overridden)

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush, from exec
- in_instruction  in  ILEN  fetched instruction
- in_addr  in  ALEN  address of the fetched instruction
- in_next_addr  in  ALEN  fall-through address
- in_exception  in  1  fetch fault flag
- prev_stalled  in  1  input NOT valid
- stall_prev  out  1  queue NOT ready to accept input
- out_instruction  out  ILEN  head instruction
- out_addr  out  ALEN  head address
- out_next_addr  out  ALEN  head next address
- out_exception  out  1  head fault flag
- next_stalled  in  1  decode NOT ready
- stall_next  out  1  output NOT valid; never depends on next_stalled
- level  out  LW  number of occupied entries

## Operation
- Storage: circular buffer of DEPTH entries, each ILEN+2*ALEN+1 bits.
- Read pointer and write pointer are each log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count register ranges 0..DEPTH; `level` = count.
- Push: at a rising edge when !prev_stalled && !stall_prev, the input is written at wptr, then wptr increments.
- Pop: at a rising edge when !stall_next && !next_stalled, rptr increments.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- stall_prev = !rst || flush || (count == DEPTH) || fault_held.
  - Combinational from registered state and flush only.
  - A full queue does not accept a push in the same cycle as a pop.
- stall_next = (count == 0). It is registered state only.
- The out_* fields always present the entry at rptr. When stall_next is high, their value is don't-care.
- fault_held: set at the edge that pushes an entry with in_exception=1. Cleared only by flush or reset. Entries already queued, including the faulting one, still drain normally.
- Flush has priority over push and pop. At the flush edge: count←0, rptr←wptr←0, fault_held←0. No push and no pop take effect at that edge.
- Reset (rst low, asynchronous): count=0, pointers=0, fault_held=0, all storage=0.
  - Resulting outputs: stall_next=1, stall_prev=1 while rst is low, level=0, out_*=0.

## Timing
- Latency: an entry pushed at edge N is presentable after edge N (stall_next low in cycle N+1). This holds when the entry is pushed into an empty queue.
- Throughput: one push and one pop per cycle, sustained for any count from 1 to DEPTH-1.
- Empty, with a push and no pop: count becomes 1. Nothing is popped, because stall_next was high.
- Full: stall_prev is high for the whole cycle. The pop at that edge lowers count to DEPTH-1, so stall_prev drops in the next cycle.
- Flush while full or holding a fault: stall_prev is high in the flush cycle and low in the next cycle (unless flush repeats). stall_next is high in the next cycle.
- Asynchronous reset asserted mid-transfer: state clears immediately, with no partial write. The first push is possible at the first edge after rst deasserts.

## Test plan
- Reset then fill: DEPTH=4. Push instr 0x00000013, 0x00100093, 0x00200113, 0x00300193 at addr 0x0,0x4,0x8,0xC with next_stalled=1. Expect level=4 and stall_prev=1. A fifth push is not accepted. Release next_stalled: outputs appear in order 0x0,0x4,0x8,0xC, one per cycle.
- Streaming: prev_stalled=0 and next_stalled=0 for 20 cycles with incrementing addresses. Expect level to stay at 1 after the first edge, one pop per cycle, no drops and no duplicates.
- Wrap-around: with random stall patterns on both sides, push 37 entries through DEPTH=4. The popped sequence must equal the pushed sequence, and level must match a reference counter each cycle.
- Flush: with 3 entries queued, assert flush for one cycle with concurrent push and pop requests. Next cycle: level=0, stall_next=1, and no entry from before the flush ever appears.
- Fault hold: push addr 0x10 with in_exception=1, then offer addr 0x14. Expect 0x14 rejected (stall_prev=1) and 0x10 popped with out_exception=1. stall_prev stays 1 until flush. After flush, 0x14 is accepted.
- Async reset: drop rst mid-cycle with 2 entries queued. Immediately: level=0, stall_next=1, out_instruction=0, and no pop is seen by decode.
